// File: rtl/id_ex_hazard_if.sv
// id_ex_hazard_if: decode-side inputs and EX-side outputs of the ID/EX stage.
// Carries stall_count only when STALL_CNT_EN is defined.
interface id_ex_hazard_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              hold;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              load_use;
  logic              stall;
`ifdef STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_ctrl, flush, hold,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, load_use, stall
`ifdef STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_ctrl, flush, hold,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, load_use, stall
`ifdef STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use detection and one-bubble insertion.
// Define STALL_CNT_EN to add a saturating 32-bit load-use stall counter.
module id_ex_hazard_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  id_ex_hazard_if.slave  bus
);
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              load_use, bubble;

  assign load_use = valid_q & ctrl_q[1] & (rd_q != 5'd0) & bus.id_valid
                  & ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));
  assign bubble   = bus.flush | load_use;

  // Bubbles load all-zero so a killed slot can never look like a RegWrite to forwarding.
  always_comb begin
    valid_d    = bubble ? 1'b0 : bus.id_valid;
    pc_d       = bubble ? '0 : bus.id_pc;
    rs1_data_d = bubble ? '0 : bus.id_rs1_data;
    rs2_data_d = bubble ? '0 : bus.id_rs2_data;
    imm_d      = bubble ? '0 : bus.id_imm;
    rs1_d      = bubble ? '0 : bus.id_rs1;
    rs2_d      = bubble ? '0 : bus.id_rs2;
    rd_d       = bubble ? '0 : bus.id_rd;
    ctrl_d     = (bubble | ~bus.id_valid) ? '0 : bus.id_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else if (!bus.hold) begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1_data = rs1_data_q;
  assign bus.ex_rs2_data = rs2_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_ctrl     = ctrl_q;
  assign bus.load_use    = load_use;
  assign bus.stall       = load_use | bus.hold;

`ifdef STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = (load_use & ~bus.hold & (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.stall_count = cnt_q;
`endif
endmodule
